// File: rtl/mock_dev_pkg.sv
// Shared types and constants for the mock device bus router.
package mock_dev_pkg;

    // Router transaction states.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        RESP,
        ERR
    } route_state_t;

    // Read data returned for unmapped or timed-out accesses.
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

    // Default peripheral windows: hit = (addr & mask) == base.
    localparam logic [31:0] S0_BASE_DEFAULT = 32'hC000_0000;
    localparam logic [31:0] S0_MASK_DEFAULT = 32'hFFFF_FFF0;
    localparam logic [31:0] S1_BASE_DEFAULT = 32'hC100_0000;
    localparam logic [31:0] S1_MASK_DEFAULT = 32'hFFFF_FF00;

    localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mock_dev_addr_decode.sv
// Combinational window decode of a core address into per-slave hit flags.
module mock_dev_addr_decode
    import mock_dev_pkg::*;
#(
    parameter int unsigned                DW      = 32,
    parameter logic        [DW-1:0]       S0_BASE = S0_BASE_DEFAULT,
    parameter logic        [DW-1:0]       S0_MASK = S0_MASK_DEFAULT,
    parameter logic        [DW-1:0]       S1_BASE = S1_BASE_DEFAULT,
    parameter logic        [DW-1:0]       S1_MASK = S1_MASK_DEFAULT
) (
    input  logic [DW-1:0] addr,
    output logic          hit0,
    output logic          hit1
);

    // Both hits are reported raw; priority between them is resolved by the router.
    always_comb begin
        hit0 = ((addr & S0_MASK) == S0_BASE);
        hit1 = ((addr & S1_MASK) == S1_BASE);
    end

endmodule

// File: rtl/mock_dev_bus_router.sv
// MMIO router between the core's M_DEVICE port and two simulated peripherals.
// Each request is registered, decoded, forwarded to one slave and answered once.
module mock_dev_bus_router
    import mock_dev_pkg::*;
#(
    parameter int unsigned                          C_M_AXI_DATA_WIDTH = 32,
    parameter logic        [C_M_AXI_DATA_WIDTH-1:0] S0_BASE            = S0_BASE_DEFAULT,
    parameter logic        [C_M_AXI_DATA_WIDTH-1:0] S0_MASK            = S0_MASK_DEFAULT,
    parameter logic        [C_M_AXI_DATA_WIDTH-1:0] S1_BASE            = S1_BASE_DEFAULT,
    parameter logic        [C_M_AXI_DATA_WIDTH-1:0] S1_MASK            = S1_MASK_DEFAULT,
    parameter int unsigned                          TIMEOUT_CYCLES     = TIMEOUT_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic                              M_DEVICE_strobe,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_DEVICE_addr,
    input  logic                              M_DEVICE_rw,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_DEVICE_byte_enable,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_DEVICE_core2dev_data,
    output logic                              M_DEVICE_data_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_DEVICE_dev2core_data,

    output logic                              S0_strobe,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     S0_addr,
    output logic                              S0_rw,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   S0_byte_enable,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     S0_core2dev_data,
    input  logic                              S0_data_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     S0_dev2core_data,

    output logic                              S1_strobe,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     S1_addr,
    output logic                              S1_rw,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   S1_byte_enable,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     S1_core2dev_data,
    input  logic                              S1_data_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     S1_dev2core_data,

    output logic [7:0]                        bus_err_count
);

    localparam int unsigned DW  = C_M_AXI_DATA_WIDTH;
    localparam int unsigned BEW = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES + 1);

    route_state_t   state_q, state_d;

    // Latched request; sel_q = 0 routes to S0, 1 routes to S1.
    logic [DW-1:0]  addr_q;
    logic           rw_q;
    logic [BEW-1:0] be_q;
    logic [DW-1:0]  wdata_q;
    logic           sel_q;

    logic [CW-1:0]  wait_cnt_q;
    logic [DW-1:0]  rdata_q;

    logic           ready_q;
    logic [DW-1:0]  resp_q;
    logic [7:0]     err_cnt_q;

    logic           hit0;
    logic           hit1;
    logic           accept;
    logic           sel_ready;
    logic [DW-1:0]  sel_rdata;
    logic           timeout;
    logic           active;
    logic           drive0;
    logic           drive1;

    mock_dev_addr_decode #(
        .DW      (DW),
        .S0_BASE (S0_BASE),
        .S0_MASK (S0_MASK),
        .S1_BASE (S1_BASE),
        .S1_MASK (S1_MASK)
    ) u_addr_decode (
        .addr (M_DEVICE_addr),
        .hit0 (hit0),
        .hit1 (hit1)
    );

    // Request acceptance, selected-slave response mux and timeout detect.
    always_comb begin
        // The data_ready cycle still belongs to the previous access.
        accept    = (state_q == IDLE) && M_DEVICE_strobe && !ready_q;
        sel_ready = sel_q ? S1_data_ready : S0_data_ready;
        sel_rdata = sel_q ? S1_dev2core_data : S0_dev2core_data;
        timeout   = (state_q == WAIT) && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a slave response beats a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (hit0 || hit1) ? REQ : ERR;
                end
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                if (sel_ready) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            RESP: state_d = IDLE;
            ERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the core request on acceptance; S0 wins when both windows hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rw_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= M_DEVICE_addr;
            rw_q    <= M_DEVICE_rw;
            be_q    <= M_DEVICE_byte_enable;
            wdata_q <= M_DEVICE_core2dev_data;
            sel_q   <= !hit0;
        end
    end

    // WAIT cycle counter, cleared while the slave strobe is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == REQ) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    // Capture slave read data only while waiting; late pulses fall through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if ((state_q == WAIT) && sel_ready) begin
            rdata_q <= sel_rdata;
        end
    end

    // Registered core response and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            resp_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            ready_q <= (state_q == RESP) || (state_q == ERR);
            if (state_q == RESP) begin
                resp_q <= rdata_q;
            end else if (state_q == ERR) begin
                resp_q <= DW'(BUS_ERR_DATA);
            end else begin
                resp_q <= '0;
            end
            if ((state_q == ERR) && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Slave-side drive: the selected slave sees the request only in REQ/WAIT,
    // everything else stays parked at zero so combinational decoders stay quiet.
    always_comb begin
        active = (state_q == REQ) || (state_q == WAIT);
        drive0 = active && !sel_q;
        drive1 = active && sel_q;

        S0_strobe        = (state_q == REQ) && !sel_q;
        S0_addr          = drive0 ? addr_q  : '0;
        S0_rw            = drive0 ? rw_q    : 1'b0;
        S0_byte_enable   = drive0 ? be_q    : '0;
        S0_core2dev_data = drive0 ? wdata_q : '0;

        S1_strobe        = (state_q == REQ) && sel_q;
        S1_addr          = drive1 ? addr_q  : '0;
        S1_rw            = drive1 ? rw_q    : 1'b0;
        S1_byte_enable   = drive1 ? be_q    : '0;
        S1_core2dev_data = drive1 ? wdata_q : '0;
    end

    assign M_DEVICE_data_ready    = ready_q;
    assign M_DEVICE_dev2core_data = resp_q;
    assign bus_err_count          = err_cnt_q;

endmodule

// File: tb/tb_mock_dev_bus_router.sv
// Bench for mock_dev_bus_router: transaction-level model plus directed scenarios.
module tb_mock_dev_bus_router;

    localparam logic [31:0] DEAD = 32'hDEADBEEF;
    localparam int          TO   = 64;
    localparam int          NONE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        M_DEVICE_strobe = 1'b0;
    logic [31:0] M_DEVICE_addr = '0;
    logic        M_DEVICE_rw = 1'b0;
    logic [3:0]  M_DEVICE_byte_enable = '0;
    logic [31:0] M_DEVICE_core2dev_data = '0;
    logic        M_DEVICE_data_ready;
    logic [31:0] M_DEVICE_dev2core_data;
    logic        S0_strobe, S0_rw, S1_strobe, S1_rw;
    logic [31:0] S0_addr, S0_core2dev_data, S1_addr, S1_core2dev_data;
    logic [3:0]  S0_byte_enable, S1_byte_enable;
    logic        S0_data_ready = 1'b0, S1_data_ready = 1'b0;
    logic [31:0] S0_dev2core_data = '0, S1_dev2core_data = '0;
    logic [7:0]  bus_err_count;

    always #5 clk = ~clk;

    mock_dev_bus_router dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .M_DEVICE_strobe        (M_DEVICE_strobe),
        .M_DEVICE_addr          (M_DEVICE_addr),
        .M_DEVICE_rw            (M_DEVICE_rw),
        .M_DEVICE_byte_enable   (M_DEVICE_byte_enable),
        .M_DEVICE_core2dev_data (M_DEVICE_core2dev_data),
        .M_DEVICE_data_ready    (M_DEVICE_data_ready),
        .M_DEVICE_dev2core_data (M_DEVICE_dev2core_data),
        .S0_strobe              (S0_strobe),
        .S0_addr                (S0_addr),
        .S0_rw                  (S0_rw),
        .S0_byte_enable         (S0_byte_enable),
        .S0_core2dev_data       (S0_core2dev_data),
        .S0_data_ready          (S0_data_ready),
        .S0_dev2core_data       (S0_dev2core_data),
        .S1_strobe              (S1_strobe),
        .S1_addr                (S1_addr),
        .S1_rw                  (S1_rw),
        .S1_byte_enable         (S1_byte_enable),
        .S1_core2dev_data       (S1_core2dev_data),
        .S1_data_ready          (S1_data_ready),
        .S1_dev2core_data       (S1_dev2core_data),
        .bus_err_count          (bus_err_count)
    );

    // One accepted access as seen by the model: all event cycles derived at accept time.
    typedef struct packed {
        logic        valid;
        int          t;      // accept cycle
        int          tgt;    // 0, 1 or NONE
        int          lat;    // slave pulse comes lat cycles after its strobe
        logic        ok;     // slave answers inside the wait window
        int          c;      // core data_ready cycle
        int          we;     // last cycle the slave is driven
        logic [31:0] addr;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] rdata;
    } tx_t;

    tx_t cur;
    int  cyc = 0;
    int  err_m = 0;
    int  n_acc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    bit  started = 1'b0;

    logic        d_strobe = 1'b0, d_rw = 1'b0, d_force_sdata = 1'b0, d_spur = 1'b0;
    logic [31:0] d_addr = '0, d_data = '0, d_sdata = '0;
    logic [3:0]  d_be = '0;
    int          d_lat = 1;

    int          dr_count = 0, last_dr_cyc = -1, s0_stb_cnt = 0, s1_stb_cnt = 0, s1_act = 0;
    logic [31:0] last_dr_data = '0;
    logic        e_dr, e_stb0, e_stb1, e_drv0, e_drv1;
    logic [31:0] e_dat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int target_of(input logic [31:0] a);
        if ((a & 32'hFFFF_FFF0) == 32'hC000_0000) return 0;
        if ((a & 32'hFFFF_FF00) == 32'hC100_0000) return 1;
        return NONE;
    endfunction

    function automatic int pick_lat();
        int r = int'($urandom_range(15));
        if (r == 0) return 0;
        if (r == 1) return TO;
        if (r == 2) return TO + 1 + int'($urandom_range(20));
        return 1 + int'($urandom_range(7));
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] r = $urandom;
        case ($urandom_range(5))
            0: return 32'hC000_0000 | {28'h0, r[3:0]};
            1: return 32'hC100_0000 | {24'h0, r[7:0]};
            2: return 32'hC000_0010;
            3: return 32'hC100_0100 | {24'h0, r[7:0]};
            default: return r;
        endcase
    endfunction

    // Advance one cycle: retire, drive core and slave inputs, accept into the model.
    task automatic tick();
        logic [31:0] sd [2];
        logic        rdy [2];
        @(posedge clk);
        #1;
        cyc++;
        if (cur.valid && cyc == cur.c && (cur.tgt == NONE || !cur.ok) && err_m < 255) err_m++;
        M_DEVICE_strobe        = d_strobe;
        M_DEVICE_addr          = d_addr;
        M_DEVICE_rw            = d_rw;
        M_DEVICE_byte_enable   = d_be;
        M_DEVICE_core2dev_data = d_data;
        for (int n = 0; n < 2; n++) begin
            sd[n]  = d_force_sdata ? d_sdata : $urandom;
            rdy[n] = 1'b0;
            if (cur.valid && cur.tgt == n && cyc == cur.t + 1 + cur.lat) begin
                rdy[n] = 1'b1;
                if (cur.ok) cur.rdata = sd[n];
            end else if (d_spur && $urandom_range(7) == 0 &&
                         !(cur.valid && cur.tgt == n && cyc >= cur.t + 2 && cyc <= cur.we)) begin
                rdy[n] = 1'b1;
            end
        end
        S0_data_ready    = rdy[0];
        S0_dev2core_data = sd[0];
        S1_data_ready    = rdy[1];
        S1_dev2core_data = sd[1];
        if (d_strobe && rst_n && !(cur.valid && cyc <= cur.c)) begin
            cur.valid = 1'b1;
            cur.t     = cyc;
            cur.tgt   = target_of(d_addr);
            cur.lat   = d_lat;
            cur.ok    = (cur.tgt != NONE) && d_lat >= 1 && d_lat <= TO;
            cur.c     = (cur.tgt == NONE) ? cyc + 2 : (cur.ok ? cyc + 3 + d_lat : cyc + 3 + TO);
            cur.we    = cur.ok ? cyc + 1 + d_lat : cyc + 1 + TO;
            cur.addr  = d_addr;
            cur.rw    = d_rw;
            cur.be    = d_be;
            cur.data  = d_data;
            cur.rdata = '0;
            n_acc++;
        end
    endtask

    // Compare every DUT output against the model once per cycle, away from the clock edge.
    always @(negedge clk) begin
        if (rst_n && started) begin
            e_dr = 1'b0; e_dat = '0; e_stb0 = 1'b0; e_stb1 = 1'b0; e_drv0 = 1'b0; e_drv1 = 1'b0;
            if (cur.valid) begin
                if (cyc == cur.c) begin
                    e_dr  = 1'b1;
                    e_dat = (cur.tgt != NONE && cur.ok) ? cur.rdata : DEAD;
                end
                if (cur.tgt != NONE && cyc >= cur.t + 1 && cyc <= cur.we) begin
                    if (cur.tgt == 0) begin
                        e_drv0 = 1'b1; e_stb0 = (cyc == cur.t + 1);
                    end else begin
                        e_drv1 = 1'b1; e_stb1 = (cyc == cur.t + 1);
                    end
                end
            end
            check("data_ready", 32'(M_DEVICE_data_ready), 32'(e_dr));
            if (e_dr) check("dev2core_data", M_DEVICE_dev2core_data, e_dat);
            check("bus_err_count", 32'(bus_err_count), 32'(err_m));
            check("s0_strobe", 32'(S0_strobe), 32'(e_stb0));
            check("s0_addr", S0_addr, e_drv0 ? cur.addr : 32'h0);
            check("s0_rw", 32'(S0_rw), e_drv0 ? 32'(cur.rw) : 32'h0);
            check("s0_be", 32'(S0_byte_enable), e_drv0 ? 32'(cur.be) : 32'h0);
            check("s0_data", S0_core2dev_data, e_drv0 ? cur.data : 32'h0);
            check("s1_strobe", 32'(S1_strobe), 32'(e_stb1));
            check("s1_addr", S1_addr, e_drv1 ? cur.addr : 32'h0);
            check("s1_rw", 32'(S1_rw), e_drv1 ? 32'(cur.rw) : 32'h0);
            check("s1_be", 32'(S1_byte_enable), e_drv1 ? 32'(cur.be) : 32'h0);
            check("s1_data", S1_core2dev_data, e_drv1 ? cur.data : 32'h0);
            if (M_DEVICE_data_ready) begin
                dr_count++;
                last_dr_cyc  = cyc;
                last_dr_data = M_DEVICE_dev2core_data;
            end
            if (S0_strobe) s0_stb_cnt++;
            if (S1_strobe) s1_stb_cnt++;
            if (S1_strobe || S1_addr != 32'h0) s1_act++;
        end
    end

    task automatic wait_idle();
        while (cur.valid && cyc < cur.c) tick();
    endtask

    task automatic run_req(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                           input int lat, output int t_acc);
        wait_idle();
        d_strobe = 1'b1; d_addr = a; d_rw = rw; d_data = wd; d_be = 4'hF; d_lat = lat;
        tick();
        t_acc    = cyc;
        d_strobe = 1'b0;
        last_dr_cyc = -1;
        while (cyc < cur.c + 1) tick();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cur      = '0;
        err_m    = 0;
        d_strobe = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int t, base, s1_before, s_before;
        cur = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_ready", 32'(M_DEVICE_data_ready), 32'h0);
        check("rst_dev2core", M_DEVICE_dev2core_data, 32'h0);
        check("rst_err_count", 32'(bus_err_count), 32'h0);
        check("rst_s0_strobe", 32'(S0_strobe), 32'h0);
        check("rst_s1_strobe", 32'(S1_strobe), 32'h0);
        check("rst_s0_addr", S0_addr, 32'h0);
        #1;
        rst_n   = 1'b1;
        started = 1'b1;
        tick();

        // UART write, slave answers 2 cycles after its strobe.
        d_force_sdata = 1'b1; d_sdata = 32'h1234_5678;
        run_req(32'hC000_0004, 1'b1, 32'h0000_0041, 2, t);
        check("t1_model_lat", 32'(cur.c - cur.t), 32'd5);
        check("t1_dut_lat", 32'(last_dr_cyc - t), 32'd5);
        check("t1_wr_return", last_dr_data, 32'h1234_5678);

        // UART status read, slave latency 3.
        d_sdata   = 32'h0000_0060;
        s1_before = s1_act;
        run_req(32'hC000_0008, 1'b0, 32'h0, 3, t);
        check("t2_model_lat", 32'(cur.c - cur.t), 32'd6);
        check("t2_dut_lat", 32'(last_dr_cyc - t), 32'd6);
        check("t2_rdata", last_dr_data, 32'h0000_0060);
        check("t2_s1_parked", 32'(s1_act - s1_before), 32'd0);
        d_force_sdata = 1'b0;

        // Unmapped read.
        check("t3_err_before", 32'(bus_err_count), 32'd0);
        s_before = s0_stb_cnt + s1_stb_cnt;
        run_req(32'h8000_0000, 1'b0, 32'h0, 1, t);
        check("t3_dut_lat", 32'(last_dr_cyc - t), 32'd2);
        check("t3_rdata", last_dr_data, DEAD);
        check("t3_err_after", 32'(bus_err_count), 32'd1);
        check("t3_no_strobe", 32'(s0_stb_cnt + s1_stb_cnt - s_before), 32'd0);

        // S1 silent through the whole window; its pulse arrives long after.
        run_req(32'hC100_0010, 1'b0, 32'h0, 100, t);
        check("t4_dut_lat", 32'(last_dr_cyc - t), 32'd67);
        check("t4_rdata", last_dr_data, DEAD);
        base = dr_count;
        while (cyc < t + 106) tick();
        check("t4_late_ignored", 32'(dr_count - base), 32'd0);

        // Reset in the middle of a WAIT.
        wait_idle();
        d_strobe = 1'b1; d_addr = 32'hC000_0008; d_rw = 1'b1; d_data = 32'hA5A5_0001; d_lat = 30;
        tick();
        t = cyc;
        d_strobe = 1'b0;
        while (cyc < t + 6) tick();
        #2;
        check("t5_held_addr", S0_addr, 32'hC000_0008);
        rst_n = 1'b0;
        cur   = '0;
        err_m = 0;
        #1;
        check("t5_rst_addr", S0_addr, 32'h0);
        check("t5_rst_rw", 32'(S0_rw), 32'h0);
        check("t5_rst_strobe", 32'(S0_strobe), 32'h0);
        check("t5_rst_ready", 32'(M_DEVICE_data_ready), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_req(32'hC000_0004, 1'b0, 32'h0, 2, t);
        check("t5_after_lat", 32'(last_dr_cyc - t), 32'd5);

        // Randomized traffic with spurious slave pulses and ignored core strobes.
        d_spur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            d_strobe = ($urandom_range(2) == 0);
            d_addr   = pick_addr();
            d_rw     = 1'($urandom_range(1));
            d_be     = 4'($urandom_range(15));
            d_data   = $urandom;
            d_lat    = pick_lat();
            tick();
        end
        d_strobe = 1'b0;
        d_spur   = 1'b0;
        while (cur.valid && cyc < cur.c + 1) tick();

        // Back-to-back unmapped accesses with the strobe held high.
        do_reset();
        base = dr_count;
        n_acc = 0;
        d_strobe = 1'b1; d_addr = 32'h8000_0000; d_rw = 1'b0; d_lat = 1;
        tick();
        t = cur.t;
        while (n_acc < 300 && cyc < t + 2000) tick();
        d_strobe = 1'b0;
        while (cyc < cur.c + 1) tick();
        check("t6_accepts", 32'(n_acc), 32'd300);
        check("t6_model_span", 32'(cur.c - t), 32'd899);
        check("t6_data_readys", 32'(dr_count - base), 32'd300);
        check("t6_model_err", 32'(err_m), 32'd255);
        check("t6_err_sat", 32'(bus_err_count), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
